morse_word_assembler: RTL and testbench

//  Parametrised successor of the single-word Morse decoder. Recognises each Morse symbol group,

---
 rtl/morse_word_assembler_pkg.sv | 75 +++++++
 rtl/morse_word_assembler_fifo.sv | 70 +++++++
 rtl/morse_word_assembler.sv | 132 +++++++++++++
 tb/tb_morse_word_assembler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/morse_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_word_assembler_pkg
// Description : Shared constants for the Morse word assembler: character
//               encoding, symbol-group sizing and the Morse-to-ASCII lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package morse_word_assembler_pkg;

  // Character encoding is plain ASCII
  localparam int CHAR_W = 8;
  typedef logic [CHAR_W-1:0] char_t;

  // Empty slot filler ('_') and unrecognised-pattern code ('?')
  localparam char_t CHAR_CODE_BLANK   = 8'h5F;
  localparam char_t CHAR_CODE_UNKNOWN = 8'h3F;

  // Longest symbol group is a digit (5 symbols)
  localparam int MAX_MORSE_LEN = 5;
  localparam int MORSE_LEN_W   = 3;

  // Morse lookup. The first symbol sits in bit 0, dit = 0, dah = 1.
  // Bits at or above the group length are ignored.
  function automatic char_t morse_recognize_char(
    input logic [MAX_MORSE_LEN-1:0] pattern,
    input logic [MORSE_LEN_W-1:0]   n
  );
    logic [MAX_MORSE_LEN-1:0] m;
    char_t c;
    m = pattern & ~({MAX_MORSE_LEN{1'b1}} << n);
    c = CHAR_CODE_UNKNOWN;
    case ({n, m})
      {3'd1, 5'b00000}: c = "E";
      {3'd1, 5'b00001}: c = "T";
      {3'd2, 5'b00000}: c = "I";
      {3'd2, 5'b00010}: c = "A";
      {3'd2, 5'b00001}: c = "N";
      {3'd2, 5'b00011}: c = "M";
      {3'd3, 5'b00000}: c = "S";
      {3'd3, 5'b00100}: c = "U";
      {3'd3, 5'b00010}: c = "R";
      {3'd3, 5'b00110}: c = "W";
      {3'd3, 5'b00001}: c = "D";
      {3'd3, 5'b00101}: c = "K";
      {3'd3, 5'b00011}: c = "G";
      {3'd3, 5'b00111}: c = "O";
      {3'd4, 5'b00000}: c = "H";
      {3'd4, 5'b01000}: c = "V";
      {3'd4, 5'b00100}: c = "F";
      {3'd4, 5'b00010}: c = "L";
      {3'd4, 5'b00110}: c = "P";
      {3'd4, 5'b01110}: c = "J";
      {3'd4, 5'b00001}: c = "B";
      {3'd4, 5'b01001}: c = "X";
      {3'd4, 5'b00101}: c = "C";
      {3'd4, 5'b01101}: c = "Y";
      {3'd4, 5'b00011}: c = "Z";
      {3'd4, 5'b01011}: c = "Q";
      {3'd5, 5'b11111}: c = "0";
      {3'd5, 5'b11110}: c = "1";
      {3'd5, 5'b11100}: c = "2";
      {3'd5, 5'b11000}: c = "3";
      {3'd5, 5'b10000}: c = "4";
      {3'd5, 5'b00000}: c = "5";
      {3'd5, 5'b00001}: c = "6";
      {3'd5, 5'b00011}: c = "7";
      {3'd5, 5'b00111}: c = "8";
      {3'd5, 5'b01111}: c = "9";
      default:          c = CHAR_CODE_UNKNOWN;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_word_assembler_fifo.sv
`default_nettype none
// ============================================================================
// Module      : morse_word_fifo
// Description : Generic synchronous FIFO with fall-through head. Head data is
//               read straight from the storage flops, so an entry pushed on
//               one edge is visible right after it. Push and pop in the same
//               cycle are both honoured, also when full; a push into a full
//               FIFO without a pop is discarded and flagged on drop.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_word_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_pop_en;
  logic w_push_en;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_en  = pop & ~empty;
  // When full, the slot being popped is the one the push overwrites
  assign w_push_en = push & (~full | w_pop_en);
  assign drop      = push & full & ~w_pop_en;
  assign head_data = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since empty masks the head
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/morse_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : morse_word_assembler
// Description : Recognises Morse symbol groups, assembles characters into a
//               word of up to MAX_CHARS, tracks length and error status and
//               queues completed words in a FIFO drained via valid/ready.
//               Optional macro MORSE_WORD_SCROLL_EN: on overflow the oldest
//               character is shifted out instead of the new one being dropped
//               and the word being flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_word_assembler
  import morse_word_assembler_pkg::*;
#(
  parameter int MAX_CHARS  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 8,
  localparam int LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        sym_valid,
  input  logic [MAX_MORSE_LEN-1:0]    dits_dahs,
  input  logic [MORSE_LEN_W-1:0]      len,
  input  logic                        word_end,
  input  logic                        error_in,
  output logic [CHAR_W*MAX_CHARS-1:0] out_word,
  output logic [LEN_W-1:0]            out_len,
  output logic                        out_error,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);

  localparam int WORD_W = CHAR_W * MAX_CHARS;
  localparam int DATA_W = WORD_W + LEN_W + 1;
  localparam logic [WORD_W-1:0] BLANK_WORD = {MAX_CHARS{CHAR_CODE_BLANK}};

  logic [WORD_W-1:0]     r_word;
  logic [LEN_W-1:0]      r_len;
  logic                  r_err;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_acc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic                  w_at_max;
  char_t                 w_char;
  logic [WORD_W-1:0]     w_word_shifted;
  logic [DATA_W-1:0]     w_head;

  assign w_acc          = ce & sym_valid;
  assign w_char         = morse_recognize_char(dits_dahs, len);
  assign w_at_max       = (r_len == LEN_W'(MAX_CHARS));
  assign w_word_shifted = {r_word[WORD_W-CHAR_W-1:0], w_char};
  // Empty words are never queued
  assign w_push         = w_acc & word_end & (r_len != '0);
  assign w_pop          = out_ready & ~w_empty;

  // Word assembly: append on symbol, clear on close, overflow policy at MAX_CHARS
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= BLANK_WORD;
      r_len  <= '0;
      r_err  <= 1'b0;
    end else if (w_acc) begin
      if (word_end) begin
        r_word <= BLANK_WORD;
        r_len  <= '0;
        r_err  <= 1'b0;
      end else if (!w_at_max) begin
        r_word <= w_word_shifted;
        r_len  <= r_len + 1'b1;
        r_err  <= r_err | error_in;
      end else begin
`ifdef MORSE_WORD_SCROLL_EN
        // Scroll: oldest char falls off the top, length stays at MAX_CHARS
        r_word <= w_word_shifted;
        r_err  <= r_err | error_in;
`else
        // Truncate: new char discarded and the word is flagged
        r_err  <= 1'b1;
`endif
      end
    end
  end

  // Saturating count of completed words lost to a full FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  morse_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({r_word, r_len, r_err}),
    .pop       (w_pop),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .drop      (w_drop)
  );

  // Head presentation; an empty FIFO shows the idle values
  always_comb begin
    out_valid = ~w_empty;
    out_word  = BLANK_WORD;
    out_len   = '0;
    out_error = 1'b0;
    if (!w_empty) begin
      out_word  = w_head[DATA_W-1 -: WORD_W];
      out_len   = w_head[LEN_W:1];
      out_error = w_head[0];
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_morse_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_word_assembler
// Description : Directed self-checking bench for morse_word_assembler with
//               MAX_CHARS=4, FIFO_DEPTH=4, DROP_CNT_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_word_assembler;

  localparam int MAX_CHARS  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int DROP_CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst, ce, sym_valid, word_end, error_in, out_ready;
  logic [4:0]  dits_dahs;
  logic [2:0]  len;
  logic [31:0] out_word;
  logic [2:0]  out_len;
  logic        out_error, out_valid;
  logic [1:0]  drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  morse_word_assembler #(
    .MAX_CHARS  (MAX_CHARS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DROP_CNT_W (DROP_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .sym_valid (sym_valid),
    .dits_dahs (dits_dahs),
    .len       (len),
    .word_end  (word_end),
    .error_in  (error_in),
    .out_word  (out_word),
    .out_len   (out_len),
    .out_error (out_error),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted strobe: append (we=0) or close (we=1)
  task automatic sym(input logic [4:0] p, input logic [2:0] l, input logic e, input logic we);
    ce = 1'b1; sym_valid = 1'b1; dits_dahs = p; len = l; error_in = e; word_end = we;
    tick();
    sym_valid = 1'b0; word_end = 1'b0; error_in = 1'b0;
  endtask

  task automatic close_word();
    sym(5'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic head(input string tag, input logic [31:0] w, input logic [2:0] l, input logic e);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_word"},  out_word, w);
    chk({tag, "_len"},   {29'd0, out_len}, {29'd0, l});
    chk({tag, "_err"},   {31'd0, out_error}, {31'd0, e});
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; sym_valid = 1'b0; word_end = 1'b0; error_in = 1'b0;
    out_ready = 1'b0; dits_dahs = '0; len = '0;
    tick(); tick();
    // Reset state
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_len",   {29'd0, out_len}, 32'd0);
    chk("rst_err",   {31'd0, out_error}, 32'd0);
    chk("rst_word",  out_word, 32'h5F5F5F5F);
    chk("rst_drop",  {30'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: "SOS", visible right after the closing edge and stable while not ready
    sym(5'b00000, 3'd3, 1'b0, 1'b0);
    sym(5'b00111, 3'd3, 1'b0, 1'b0);
    sym(5'b00000, 3'd3, 1'b0, 1'b0);
    chk("sos_notyet", {31'd0, out_valid}, 32'd0);
    close_word();
    head("sos", 32'h5F534F53, 3'd3, 1'b0);
    tick();
    head("sos_hold", 32'h5F534F53, 3'd3, 1'b0);
    pop1();
    chk("sos_popped", {31'd0, out_valid}, 32'd0);

    // ce low blocks both append and close
    ce = 1'b0; sym_valid = 1'b1; dits_dahs = 5'b0; len = 3'd1; tick();
    word_end = 1'b1; tick();
    sym_valid = 1'b0; word_end = 1'b0;
    chk("ce_gate", {31'd0, out_valid}, 32'd0);

    // 2: empty closes never queue
    close_word(); close_word(); close_word();
    chk("empty_valid", {31'd0, out_valid}, 32'd0);
    chk("empty_drop",  {30'd0, drop_cnt}, 32'd0);

    // 3: error flag on the flagged word only
    sym(5'b00010, 3'd2, 1'b0, 1'b0);   // A
    sym(5'b00001, 3'd2, 1'b1, 1'b0);   // N with error
    close_word();
    sym(5'b00000, 3'd1, 1'b0, 1'b0);   // E
    sym(5'b00001, 3'd1, 1'b0, 1'b0);   // T
    close_word();
    head("err_word", 32'h5F5F414E, 3'd2, 1'b1);
    pop1();
    head("clean_word", 32'h5F5F4554, 3'd2, 1'b0);
    pop1();
    chk("err_drained", {31'd0, out_valid}, 32'd0);

    // 4: overflow with A..F
    sym(5'b00010, 3'd2, 1'b0, 1'b0);   // A
    sym(5'b00001, 3'd4, 1'b0, 1'b0);   // B
    sym(5'b00101, 3'd4, 1'b0, 1'b0);   // C
    sym(5'b00001, 3'd3, 1'b0, 1'b0);   // D
    sym(5'b00000, 3'd1, 1'b0, 1'b0);   // E
    sym(5'b00100, 3'd4, 1'b0, 1'b0);   // F
    close_word();
`ifdef MORSE_WORD_SCROLL_EN
    head("ovf", 32'h43444546, 3'd4, 1'b0);
`else
    head("ovf", 32'h41424344, 3'd4, 1'b1);
`endif
    pop1();

    // 5: six words into depth four, then push+pop while full
    sym(5'b00000, 3'd1, 1'b0, 1'b0); close_word();   // E
    sym(5'b00001, 3'd1, 1'b0, 1'b0); close_word();   // T
    sym(5'b00000, 3'd2, 1'b0, 1'b0); close_word();   // I
    sym(5'b00010, 3'd2, 1'b0, 1'b0); close_word();   // A
    sym(5'b00001, 3'd2, 1'b0, 1'b0); close_word();   // N (dropped)
    sym(5'b00011, 3'd2, 1'b0, 1'b0); close_word();   // M (dropped)
    chk("full_drop", {30'd0, drop_cnt}, 32'd2);
    head("full_head", 32'h5F5F5F45, 3'd1, 1'b0);
    sym(5'b00000, 3'd3, 1'b0, 1'b0);                 // S
    out_ready = 1'b1;
    close_word();
    out_ready = 1'b0;
    chk("pushpop_drop", {30'd0, drop_cnt}, 32'd2);
    head("q_t", 32'h5F5F5F54, 3'd1, 1'b0);
    pop1();
    head("q_i", 32'h5F5F5F49, 3'd1, 1'b0);
    pop1();
    head("q_a", 32'h5F5F5F41, 3'd1, 1'b0);
    pop1();
    head("q_s", 32'h5F5F5F53, 3'd1, 1'b0);
    pop1();
    chk("q_empty", {31'd0, out_valid}, 32'd0);

    // Drop counter saturates at all-ones
    for (int i = 0; i < 7; i++) begin
      sym(5'b00000, 3'd1, 1'b0, 1'b0);
      close_word();
    end
    chk("drop_sat", {30'd0, drop_cnt}, 32'd3);

    // 6: reset mid-word with a full queue
    sym(5'b00001, 3'd1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_drop",  {30'd0, drop_cnt}, 32'd0);
    chk("rst2_word",  out_word, 32'h5F5F5F5F);
    sym(5'b00000, 3'd1, 1'b0, 1'b0);   // E
    close_word();
    head("post_rst", 32'h5F5F5F45, 3'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
